compare_request_scheduler: RTL and testbench

// Shares the single 4-bit magnitude comparator between NUM_REQ requesters (branch unit, loop

---
 rtl/compare_request_scheduler.sv | 146 ++++++++++++++
 tb/tb_compare_request_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/compare_request_scheduler.sv
// rtl/compare_request_scheduler.sv - round-robin sharing of one magnitude comparator among NUM_REQ requesters
module compare_request_scheduler #(
   parameter int WIDTH   = 4,
   parameter int NUM_REQ = 4,
   localparam int IDW    = $clog2(NUM_REQ)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*WIDTH-1:0]   req_a,
   input  logic [NUM_REQ*WIDTH-1:0]   req_b,
   input  logic [NUM_REQ*2-1:0]       req_mode,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic [WIDTH-1:0]           cmp_a,
   output logic [WIDTH-1:0]           cmp_b,
   output logic                       cmp_is_equal,
   output logic                       cmp_is_greater,
   output logic                       cmp_is_less,
   input  logic                       cmp_equal,
   input  logic                       cmp_a_greater,
   input  logic                       cmp_a_less,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [IDW-1:0]             rsp_id,
   output logic                       rsp_result,
   output logic [2:0]                 rsp_flags,
   output logic                       busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      RESPOND = 2'd2
   } state_t;

   localparam logic [1:0] MODE_EQ = 2'b00;
   localparam logic [1:0] MODE_GT = 2'b01;
   localparam logic [1:0] MODE_LT = 2'b10;

   state_t           state;
   logic [IDW-1:0]   rr_ptr;
   logic [1:0]       lat_mode;
   logic [IDW-1:0]   lat_id;

   logic [WIDTH-1:0] a_arr    [NUM_REQ];
   logic [WIDTH-1:0] b_arr    [NUM_REQ];
   logic [1:0]       mode_arr [NUM_REQ];

   logic             grant_found;
   logic [IDW-1:0]   grant_idx;
   logic [IDW:0]     cand_sum;
   logic [IDW-1:0]   cand_idx;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign a_arr[i]    = req_a[i*WIDTH +: WIDTH];
      assign b_arr[i]    = req_b[i*WIDTH +: WIDTH];
      assign mode_arr[i] = req_mode[i*2 +: 2];
   end

   // Search starts one past the last winner so every active requester gets a turn.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand_sum    = '0;
      cand_idx    = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand_sum = {1'b0, rr_ptr} + (IDW+1)'(k);
         if (cand_sum >= (IDW+1)'(NUM_REQ)) begin
            cand_sum = cand_sum - (IDW+1)'(NUM_REQ);
         end
         cand_idx = cand_sum[IDW-1:0];
         if (!grant_found && req_valid[cand_idx]) begin
            grant_found = 1'b1;
            grant_idx   = cand_idx;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (!rst && state == IDLE && grant_found) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         rr_ptr         <= IDW'(NUM_REQ-1);
         lat_mode       <= '0;
         lat_id         <= '0;
         cmp_a          <= '0;
         cmp_b          <= '0;
         cmp_is_equal   <= 1'b0;
         cmp_is_greater <= 1'b0;
         cmp_is_less    <= 1'b0;
         rsp_valid      <= 1'b0;
         rsp_id         <= '0;
         rsp_result     <= 1'b0;
         rsp_flags      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_found) begin
                  cmp_a          <= a_arr[grant_idx];
                  cmp_b          <= b_arr[grant_idx];
                  lat_mode       <= mode_arr[grant_idx];
                  lat_id         <= grant_idx;
                  cmp_is_equal   <= (mode_arr[grant_idx] == MODE_EQ);
                  cmp_is_greater <= (mode_arr[grant_idx] == MODE_GT);
                  cmp_is_less    <= (mode_arr[grant_idx] == MODE_LT);
                  rr_ptr         <= grant_idx;
                  state          <= ISSUE;
               end
            end
            ISSUE: begin
               cmp_is_equal   <= 1'b0;
               cmp_is_greater <= 1'b0;
               cmp_is_less    <= 1'b0;
               rsp_flags      <= {cmp_a_less, cmp_a_greater, cmp_equal};
               rsp_id         <= lat_id;
               rsp_valid      <= 1'b1;
               case (lat_mode)
                  MODE_EQ: rsp_result <= cmp_equal;
                  MODE_GT: rsp_result <= cmp_a_greater;
                  MODE_LT: rsp_result <= cmp_a_less;
                  default: rsp_result <= 1'b0;
               endcase
               state <= RESPOND;
            end
            RESPOND: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_compare_request_scheduler.sv
// tb/tb_compare_request_scheduler.sv - randomized and directed bench against a transaction-level model
module tb_compare_request_scheduler;
   localparam int WIDTH   = 4;
   localparam int NUM_REQ = 4;
   localparam int IDW     = 2;

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic [NUM_REQ-1:0]       req_valid = '0;
   logic [NUM_REQ*WIDTH-1:0] req_a = '0;
   logic [NUM_REQ*WIDTH-1:0] req_b = '0;
   logic [NUM_REQ*2-1:0]     req_mode = '0;
   logic [NUM_REQ-1:0]       req_ready;
   logic [WIDTH-1:0]         cmp_a, cmp_b;
   logic                     cmp_is_equal, cmp_is_greater, cmp_is_less;
   logic                     cmp_equal, cmp_a_greater, cmp_a_less;
   logic                     rsp_valid;
   logic                     rsp_ready = 1'b1;
   logic [IDW-1:0]           rsp_id;
   logic                     rsp_result;
   logic [2:0]               rsp_flags;
   logic                     busy;

   compare_request_scheduler #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_mode(req_mode),
      .req_ready(req_ready),
      .cmp_a(cmp_a), .cmp_b(cmp_b),
      .cmp_is_equal(cmp_is_equal), .cmp_is_greater(cmp_is_greater), .cmp_is_less(cmp_is_less),
      .cmp_equal(cmp_equal), .cmp_a_greater(cmp_a_greater), .cmp_a_less(cmp_a_less),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Stand-in for the datapath comparator.
   assign cmp_equal     = (cmp_a == cmp_b);
   assign cmp_a_greater = (cmp_a >  cmp_b);
   assign cmp_a_less    = (cmp_a <  cmp_b);

   int checks = 0;
   int passes = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
   endtask

   // Requester side: pending request per requester.
   bit         pend [NUM_REQ];
   logic [3:0] pa   [NUM_REQ];
   logic [3:0] pb   [NUM_REQ];
   logic [1:0] pm   [NUM_REQ];

   // Scheduler reference: one transaction in flight, aged by clock edges since acceptance.
   bit         m_active;
   int         m_age;
   int         m_ptr;
   logic [3:0] m_a, m_b;
   logic [1:0] m_mode;
   int         m_id;
   int         dut_grants[$];

   task automatic set_req(input int i, input int a, input int b, input int mode);
      pend[i] = 1'b1;
      pa[i]   = 4'(a);
      pb[i]   = 4'(b);
      pm[i]   = 2'(mode);
   endtask

   task automatic drive();
      for (int i = 0; i < NUM_REQ; i++) begin
         req_valid[i]           = pend[i];
         req_a[i*WIDTH +: WIDTH] = pa[i];
         req_b[i*WIDTH +: WIDTH] = pb[i];
         req_mode[i*2 +: 2]     = pm[i];
      end
   endtask

   function automatic int model_grant();
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (pend[(m_ptr + k) % NUM_REQ]) return (m_ptr + k) % NUM_REQ;
      end
      return -1;
   endfunction

   function automatic logic [2:0] sel_of(input logic [1:0] mode);
      case (mode)
         2'd0:    return 3'b001;
         2'd1:    return 3'b010;
         2'd2:    return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic result_of(input logic [1:0] mode, input logic [3:0] a, input logic [3:0] b);
      case (mode)
         2'd0:    return a == b;
         2'd1:    return a > b;
         2'd2:    return a < b;
         default: return 1'b0;
      endcase
   endfunction

   // Called just after a falling edge; checks this cycle, then advances one clock.
   task automatic step();
      int         g;
      logic [3:0] exp_ready;
      logic [2:0] exp_sel;
      bit         hs;
      drive();
      #1;
      g         = m_active ? -1 : model_grant();
      exp_ready = (g >= 0) ? 4'(1 << g) : 4'd0;
      for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) dut_grants.push_back(i);
      check("req_ready", req_ready, exp_ready);
      check("busy", busy, m_active);
      check("rsp_valid", rsp_valid, m_active && m_age >= 2);
      exp_sel = (m_active && m_age == 1) ? sel_of(m_mode) : 3'b000;
      check("cmp_sel", {cmp_is_less, cmp_is_greater, cmp_is_equal}, exp_sel);
      if (m_active && m_age == 1) begin
         check("cmp_a", cmp_a, m_a);
         check("cmp_b", cmp_b, m_b);
      end
      if (m_active && m_age >= 2) begin
         check("rsp_id", rsp_id, m_id);
         check("rsp_flags", rsp_flags, {m_a < m_b, m_a > m_b, m_a == m_b});
         check("rsp_result", rsp_result, result_of(m_mode, m_a, m_b));
      end
      hs = m_active && m_age >= 2 && rsp_ready;
      if (hs) m_active = 1'b0;
      else if (m_active) m_age++;
      if (g >= 0) begin
         m_active = 1'b1;
         m_age    = 1;
         m_ptr    = g;
         m_a      = pa[g];
         m_b      = pb[g];
         m_mode   = pm[g];
         m_id     = g;
         pend[g]  = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic reset_now();
      rst = 1'b1;
      #1;
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_req_ready", req_ready, 4'd0);
      check("rst_cmp_sel", {cmp_is_less, cmp_is_greater, cmp_is_equal}, 3'b000);
      m_active = 1'b0;
      m_ptr    = NUM_REQ - 1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic clear_all();
      for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < NUM_REQ; i++) begin
         pend[i] = 1'b0; pa[i] = '0; pb[i] = '0; pm[i] = '0;
      end
      m_active = 1'b0;
      m_age    = 0;
      m_ptr    = NUM_REQ - 1;
      m_a = '0; m_b = '0; m_mode = '0; m_id = 0;

      // Reset state, with a request present to show req_ready is held off.
      pend[1] = 1'b1;
      drive();
      @(negedge clk);
      @(negedge clk);
      #1;
      check("reset_cmp_a", cmp_a, 4'd0);
      check("reset_cmp_b", cmp_b, 4'd0);
      check("reset_sel", {cmp_is_less, cmp_is_greater, cmp_is_equal}, 3'b000);
      check("reset_rsp_valid", rsp_valid, 1'b0);
      check("reset_busy", busy, 1'b0);
      check("reset_req_ready", req_ready, 4'd0);
      check("reset_rsp", {rsp_id, rsp_result, rsp_flags}, 6'd0);
      pend[1] = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // Single requests covering each mode.
      rsp_ready = 1'b1;
      set_req(0, 5, 5, 0);  repeat (4) step();
      set_req(1, 12, 3, 1); repeat (4) step();
      set_req(2, 3, 12, 1); repeat (4) step();
      set_req(3, 3, 12, 3); repeat (4) step();

      // All requesters active: strict rotation from requester 0.
      dut_grants.delete();
      for (int c = 0; c < 16; c++) begin
         for (int i = 0; i < NUM_REQ; i++)
            if (!pend[i]) set_req(i, $urandom_range(15), $urandom_range(15), $urandom_range(3));
         step();
      end
      check("rr_count", dut_grants.size() >= 5, 1'b1);
      for (int k = 0; k < 5 && k < dut_grants.size(); k++) check("rr_order", dut_grants[k], k % NUM_REQ);
      clear_all();
      repeat (4) step();

      // Backpressure: response held for several cycles with others waiting.
      set_req(1, 9, 2, 2);
      set_req(2, 7, 7, 0);
      repeat (2) step();
      rsp_ready = 1'b0;
      repeat (5) step();
      rsp_ready = 1'b1;
      repeat (6) step();

      // Withdrawal: requester 2 drops before its turn, requester 3 is taken.
      reset_now();
      set_req(1, 4, 8, 2);
      step();
      set_req(2, 1, 1, 0);
      set_req(3, 6, 2, 1);
      repeat (2) step();
      pend[2] = 1'b0;
      dut_grants.delete();
      repeat (4) step();
      check("withdraw_grant", (dut_grants.size() > 0) ? dut_grants[0] : -1, 3);

      // Reset during RESPOND; waiting requester is served afterwards.
      rsp_ready = 1'b0;
      set_req(0, 10, 11, 2);
      repeat (3) step();
      set_req(2, 15, 0, 1);
      reset_now();
      rsp_ready = 1'b1;
      dut_grants.delete();
      repeat (4) step();
      check("post_reset_grant", (dut_grants.size() > 0) ? dut_grants[0] : -1, 2);

      // Randomized traffic with withdrawals and backpressure.
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!pend[i] && ($urandom % 4) == 0)
               set_req(i, $urandom_range(15), $urandom_range(15), $urandom_range(3));
            else if (pend[i] && ($urandom % 16) == 0)
               pend[i] = 1'b0;
         end
         rsp_ready = ($urandom % 4) != 0;
         step();
      end
      clear_all();
      rsp_ready = 1'b1;
      repeat (4) step();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
